// File: rtl/rtype_pkg.sv
// Shared encodings for the R-type execution controller: funct codes,
// ALU operation selects, controller states and the funct decoder.
package rtype_pkg;

   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;

   localparam logic [5:0] OPC_RTYPE = 6'h00;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SLT = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DECODE = 2'b01,
      EXEC   = 2'b10,
      WB     = 2'b11
   } state_e;

   typedef struct packed {
      logic    legal;
      logic    ainv;
      logic    binv;
      logic    cin;
      alu_op_e op;
   } alu_ctrl_t;

   // Rejected instructions drive all ALU controls low.
   localparam alu_ctrl_t CTRL_ILLEGAL = '{legal: 1'b0, ainv: 1'b0, binv: 1'b0,
                                          cin: 1'b0, op: OP_AND};

   // Map opcode/funct onto the ripple-ALU control lines.
   function automatic alu_ctrl_t decode_rtype(input logic [5:0] opcode,
                                              input logic [5:0] funct);
      alu_ctrl_t ctrl;
      ctrl = CTRL_ILLEGAL;
      if (opcode == OPC_RTYPE) begin
         case (funct)
            FN_ADD:  ctrl = '{legal: 1'b1, ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: OP_ADD};
            FN_SUB:  ctrl = '{legal: 1'b1, ainv: 1'b0, binv: 1'b1, cin: 1'b1, op: OP_ADD};
            FN_AND:  ctrl = '{legal: 1'b1, ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: OP_AND};
            FN_OR:   ctrl = '{legal: 1'b1, ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: OP_OR};
            FN_NOR:  ctrl = '{legal: 1'b1, ainv: 1'b1, binv: 1'b1, cin: 1'b0, op: OP_AND};
            FN_SLT:  ctrl = '{legal: 1'b1, ainv: 1'b0, binv: 1'b1, cin: 1'b1, op: OP_SLT};
            default: ctrl = CTRL_ILLEGAL;
         endcase
      end else begin
         ctrl = CTRL_ILLEGAL;
      end
      return ctrl;
   endfunction

endpackage

// File: rtl/rtype_exec_ctrl_if.sv
// Instruction handshake, ALU drive/return and completion status bundle.
// slave = the controller, master = instruction source plus ALU side.
interface rtype_exec_ctrl_if #(
   parameter int XLEN = 64
);
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;

   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic            alu_ainv;
   logic            alu_binv;
   logic            alu_cin;
   logic [1:0]      alu_op;
   logic [XLEN-1:0] alu_result;
   logic            alu_cout;
   logic            alu_zero;

   logic            done;
   logic            illegal;
   logic            zero_out;
   logic            cout_out;

   modport slave (
      input  instr_valid, instr, alu_result, alu_cout, alu_zero,
      output instr_ready, alu_a, alu_b, alu_ainv, alu_binv, alu_cin, alu_op,
             done, illegal, zero_out, cout_out
   );

   modport master (
      output instr_valid, instr, alu_result, alu_cout, alu_zero,
      input  instr_ready, alu_a, alu_b, alu_ainv, alu_binv, alu_cin, alu_op,
             done, illegal, zero_out, cout_out
   );
endinterface

// File: rtl/regfile_2r1w.sv
// NREG x XLEN register file: two operand read ports, one debug read port,
// one synchronous write port; register 0 reads as zero and ignores writes.
module regfile_2r1w #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr_a,
   output logic [XLEN-1:0] rdata_a,
   input  logic [AW-1:0]   raddr_b,
   output logic [XLEN-1:0] rdata_b,
   input  logic [AW-1:0]   raddr_d,
   output logic [XLEN-1:0] rdata_d
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   // Next-state of the array: apply the single write, never to register 0.
   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != {AW{1'b0}})) begin
         regs_d[waddr] = wdata;
      end else begin
         regs_d = regs_q;
      end
   end

   // Storage update with synchronous clear of every register.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: {XLEN{1'b0}}};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a = (raddr_a == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[raddr_a];
   assign rdata_b = (raddr_b == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[raddr_b];
   assign rdata_d = (raddr_d == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[raddr_d];

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type execution controller: IDLE -> DECODE -> EXEC -> WB.
// Drives an external combinational 64-bit ripple ALU and writes back to rd.
module rtype_exec_ctrl
   import rtype_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   rtype_exec_ctrl_if.slave  bus,
   input  logic              dbg_we,
   input  logic [4:0]        dbg_addr,
   input  logic [XLEN-1:0]   dbg_wdata,
   output logic [XLEN-1:0]   dbg_rdata
);

   state_e          state_q,     state_d;
   logic [5:0]      opcode_q,    opcode_d;
   logic [4:0]      rs_q,        rs_d;
   logic [4:0]      rt_q,        rt_d;
   logic [4:0]      rd_q,        rd_d;
   logic [5:0]      funct_q,     funct_d;
   logic [XLEN-1:0] alu_a_q,     alu_a_d;
   logic [XLEN-1:0] alu_b_q,     alu_b_d;
   logic            ainv_q,      ainv_d;
   logic            binv_q,      binv_d;
   logic            cin_q,       cin_d;
   alu_op_e         alu_op_q,    alu_op_d;
   logic            ill_pend_q,  ill_pend_d;
   logic [XLEN-1:0] result_q,    result_d;
   logic            zero_cap_q,  zero_cap_d;
   logic            cout_cap_q,  cout_cap_d;
   logic            ready_q,     ready_d;
   logic            done_q,      done_d;
   logic            illegal_q,   illegal_d;
   logic            zero_out_q,  zero_out_d;
   logic            cout_out_q,  cout_out_d;

   logic            rf_we_s;
   logic [4:0]      rf_waddr_s;
   logic [XLEN-1:0] rf_wdata_s;
   logic [XLEN-1:0] rs_data_s;
   logic [XLEN-1:0] rt_data_s;
   alu_ctrl_t       ctrl_s;
   logic            unused_shamt_s;

   // shamt has no role in any supported operation.
   assign unused_shamt_s = ^bus.instr[10:6];
   assign ctrl_s = decode_rtype(opcode_q, funct_q);

   regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we_s),
      .waddr   (rf_waddr_s),
      .wdata   (rf_wdata_s),
      .raddr_a (rs_q),
      .rdata_a (rs_data_s),
      .raddr_b (rt_q),
      .rdata_b (rt_data_s),
      .raddr_d (dbg_addr),
      .rdata_d (dbg_rdata)
   );

   // FSM next-state, datapath captures and the shared write-port mux.
   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      funct_d    = funct_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      ainv_d     = ainv_q;
      binv_d     = binv_q;
      cin_d      = cin_q;
      alu_op_d   = alu_op_q;
      ill_pend_d = ill_pend_q;
      result_d   = result_q;
      zero_cap_d = zero_cap_q;
      cout_cap_d = cout_cap_q;
      illegal_d  = illegal_q;
      zero_out_d = zero_out_q;
      cout_out_d = cout_out_q;
      done_d     = 1'b0;
      rf_we_s    = 1'b0;
      rf_waddr_s = dbg_addr;
      rf_wdata_s = dbg_wdata;

      case (state_q)
         IDLE: begin
            // Preload commits on the same edge as an accept, so DECODE sees it.
            if (dbg_we) begin
               rf_we_s    = 1'b1;
               rf_waddr_s = dbg_addr;
               rf_wdata_s = dbg_wdata;
            end else begin
               rf_we_s    = 1'b0;
            end
            if (bus.instr_valid && ready_q) begin
               opcode_d = bus.instr[31:26];
               rs_d     = bus.instr[25:21];
               rt_d     = bus.instr[20:16];
               rd_d     = bus.instr[15:11];
               funct_d  = bus.instr[5:0];
               state_d  = DECODE;
            end else begin
               state_d  = IDLE;
            end
         end
         DECODE: begin
            alu_a_d    = rs_data_s;
            alu_b_d    = rt_data_s;
            ainv_d     = ctrl_s.ainv;
            binv_d     = ctrl_s.binv;
            cin_d      = ctrl_s.cin;
            alu_op_d   = ctrl_s.op;
            ill_pend_d = ~ctrl_s.legal;
            state_d    = EXEC;
         end
         EXEC: begin
            // ALU output is discarded for a rejected instruction.
            if (ill_pend_q) begin
               result_d   = {XLEN{1'b0}};
               zero_cap_d = 1'b0;
               cout_cap_d = 1'b0;
            end else begin
               result_d   = bus.alu_result;
               zero_cap_d = bus.alu_zero;
               cout_cap_d = bus.alu_cout;
            end
            state_d = WB;
         end
         WB: begin
            if (!ill_pend_q && (rd_q != 5'd0)) begin
               rf_we_s    = 1'b1;
               rf_waddr_s = rd_q;
               rf_wdata_s = result_q;
            end else begin
               rf_we_s    = 1'b0;
            end
            done_d     = 1'b1;
            illegal_d  = ill_pend_q;
            zero_out_d = zero_cap_q;
            cout_out_d = cout_cap_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   // All controller state and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         opcode_q   <= 6'd0;
         rs_q       <= 5'd0;
         rt_q       <= 5'd0;
         rd_q       <= 5'd0;
         funct_q    <= 6'd0;
         alu_a_q    <= {XLEN{1'b0}};
         alu_b_q    <= {XLEN{1'b0}};
         ainv_q     <= 1'b0;
         binv_q     <= 1'b0;
         cin_q      <= 1'b0;
         alu_op_q   <= OP_AND;
         ill_pend_q <= 1'b0;
         result_q   <= {XLEN{1'b0}};
         zero_cap_q <= 1'b0;
         cout_cap_q <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         zero_out_q <= 1'b0;
         cout_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         funct_q    <= funct_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         ainv_q     <= ainv_d;
         binv_q     <= binv_d;
         cin_q      <= cin_d;
         alu_op_q   <= alu_op_d;
         ill_pend_q <= ill_pend_d;
         result_q   <= result_d;
         zero_cap_q <= zero_cap_d;
         cout_cap_q <= cout_cap_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         illegal_q  <= illegal_d;
         zero_out_q <= zero_out_d;
         cout_out_q <= cout_out_d;
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_ainv    = ainv_q;
   assign bus.alu_binv    = binv_q;
   assign bus.alu_cin     = cin_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.done        = done_q;
   assign bus.illegal     = illegal_q;
   assign bus.zero_out    = zero_out_q;
   assign bus.cout_out    = cout_out_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Scoreboard bench for rtype_exec_ctrl with a behavioural ripple-ALU model.
module tb_rtype_exec_ctrl;
   import rtype_pkg::*;

   localparam int XLEN = 64;

   // Expected-control encodings {ainv, binv, cin, op[1:0]}
   localparam logic [4:0] C_ADD = 5'b00010;
   localparam logic [4:0] C_SUB = 5'b01110;
   localparam logic [4:0] C_AND = 5'b00000;
   localparam logic [4:0] C_OR  = 5'b00001;
   localparam logic [4:0] C_NOR = 5'b11000;
   localparam logic [4:0] C_SLT = 5'b01111;
   localparam logic [4:0] C_ILL = 5'b00000;

   typedef struct {
      string      name;
      logic       ill;
      logic       zero;
      logic       cout;
      logic       chk_zc;
      logic [4:0] ctrl;
      int         acc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            dbg_we = 1'b0;
   logic [4:0]      dbg_addr = 5'd0;
   logic [XLEN-1:0] dbg_wdata = 64'd0;
   logic [XLEN-1:0] dbg_rdata;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   rtype_exec_ctrl_if #(.XLEN(XLEN)) bus ();

   rtype_exec_ctrl #(.XLEN(XLEN), .NREG(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 64-bit ripple ALU
   logic [XLEN-1:0] a_eff, b_eff, res;
   logic [XLEN:0]   sum;
   always_comb begin
      a_eff = bus.alu_ainv ? ~bus.alu_a : bus.alu_a;
      b_eff = bus.alu_binv ? ~bus.alu_b : bus.alu_b;
      sum   = {1'b0, a_eff} + {1'b0, b_eff} + {{XLEN{1'b0}}, bus.alu_cin};
      case (bus.alu_op)
         2'b00:   res = a_eff & b_eff;
         2'b01:   res = a_eff | b_eff;
         2'b10:   res = sum[XLEN-1:0];
         default: res = {{(XLEN-1){1'b0}}, sum[XLEN-1]};
      endcase
      bus.alu_result = res;
      bus.alu_cout   = sum[XLEN];
      bus.alu_zero   = (res == {XLEN{1'b0}});
   end

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rinstr(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
      return {opc, rs, rt, rd, sh, fn};
   endfunction

   function automatic exp_t mk(input string name, input logic ill, input logic zero,
                               input logic cout, input logic chk_zc, input logic [4:0] ctrl);
      exp_t e;
      e.name = name; e.ill = ill; e.zero = zero; e.cout = cout;
      e.chk_zc = chk_zc; e.ctrl = ctrl; e.acc = 0;
      return e;
   endfunction

   // Monitor: compare every completion against the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: done=1 at cycle %0d, expected no completion", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc), 64'd4);
            check({mon_e.name, "_illegal"}, {63'd0, bus.illegal}, {63'd0, mon_e.ill});
            check({mon_e.name, "_ctrl"},
                  {59'd0, bus.alu_ainv, bus.alu_binv, bus.alu_cin, bus.alu_op},
                  {59'd0, mon_e.ctrl});
            if (mon_e.chk_zc) begin
               check({mon_e.name, "_zero"}, {63'd0, bus.zero_out}, {63'd0, mon_e.zero});
               check({mon_e.name, "_cout"}, {63'd0, bus.cout_out}, {63'd0, mon_e.cout});
            end
         end
      end
   end

   task automatic preload(input logic [4:0] a, input logic [XLEN-1:0] d);
      @(negedge clk);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      @(negedge clk);
      dbg_we = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [4:0] a, input logic [XLEN-1:0] exp);
      dbg_addr = a;
      #1;
      check(name, dbg_rdata, exp);
   endtask

   // Offer one instruction; returns at the negedge of the DECODE cycle
   task automatic issue(input logic [31:0] ins, input exp_t e, input bit expect_done);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: instr_ready=0 after 20 cycles, expected 1", e.name);
      end else begin
         bus.instr_valid = 1'b1;
         bus.instr = ins;
         e.acc = cyc;
         if (expect_done) exp_q.push_back(e);
         @(negedge clk);
         bus.instr_valid = 1'b0;
         bus.instr = rinstr(6'h00, 5'd1, 5'd1, 5'd13, 5'd0, FN_ADD);
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d completions outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   logic [31:0] stream [3];
   exp_t        stream_e [3];
   int          dcount;

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr = 32'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state and register clearing
      preload(5'd9, 64'h99);
      rd_check("preload_r9", 5'd9, 64'h99);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("rst_ready",    {63'd0, bus.instr_ready}, 64'd1);
      check("rst_done",     {63'd0, bus.done}, 64'd0);
      check("rst_illegal",  {63'd0, bus.illegal}, 64'd0);
      check("rst_zero_out", {63'd0, bus.zero_out}, 64'd0);
      check("rst_cout_out", {63'd0, bus.cout_out}, 64'd0);
      rd_check("rst_r9_cleared", 5'd9, 64'd0);

      // add r3,r1,r2 with r2 preloaded in the accept cycle, nonzero shamt
      preload(5'd1, 64'd5);
      @(negedge clk);
      dbg_we = 1'b1; dbg_addr = 5'd2; dbg_wdata = 64'd3;
      bus.instr_valid = 1'b1;
      bus.instr = rinstr(6'h00, 5'd1, 5'd2, 5'd3, 5'd7, FN_ADD);
      mon_e = mk("add_r3", 1'b0, 1'b0, 1'b0, 1'b1, C_ADD);
      mon_e.acc = cyc;
      exp_q.push_back(mon_e);
      @(negedge clk);
      dbg_we = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr = 32'hFFFF_FFFF;
      check("busy_ready_low", {63'd0, bus.instr_ready}, 64'd0);
      wait_done("add_r3");
      rd_check("add_r3_val", 5'd3, 64'd8);

      // sub r4 = 7-7, debug writes while busy must be ignored
      preload(5'd1, 64'd7); preload(5'd2, 64'd7); preload(5'd4, 64'hAA);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd4, 5'd0, FN_SUB),
            mk("sub_r4", 1'b0, 1'b1, 1'b1, 1'b1, C_SUB), 1'b1);
      dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 64'h1234;
      @(negedge clk); @(negedge clk);
      dbg_we = 1'b0;
      wait_done("sub_r4");
      rd_check("sub_r4_val", 5'd4, 64'd0);
      rd_check("busy_dbg_ignored", 5'd12, 64'd0);

      // add wrap-around: all-ones + 1
      preload(5'd1, 64'hFFFF_FFFF_FFFF_FFFF); preload(5'd2, 64'd1); preload(5'd5, 64'h55);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd5, 5'd0, FN_ADD),
            mk("add_wrap", 1'b0, 1'b1, 1'b1, 1'b1, C_ADD), 1'b1);
      wait_done("add_wrap");
      rd_check("add_wrap_r5", 5'd5, 64'd0);

      // rd = r0 and direct preload of r0 are both dropped
      preload(5'd1, 64'd5); preload(5'd2, 64'd3); preload(5'd0, 64'h77);
      rd_check("r0_preload_dropped", 5'd0, 64'd0);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, FN_ADD),
            mk("add_r0", 1'b0, 1'b0, 1'b0, 1'b1, C_ADD), 1'b1);
      wait_done("add_r0");
      rd_check("add_r0_val", 5'd0, 64'd0);

      // Illegal funct and illegal opcode
      preload(5'd6, 64'h66);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h3F),
            mk("ill_funct", 1'b1, 1'b0, 1'b0, 1'b0, C_ILL), 1'b1);
      issue(rinstr(6'h08, 5'd1, 5'd2, 5'd6, 5'd0, FN_ADD),
            mk("ill_opcode", 1'b1, 1'b0, 1'b0, 1'b0, C_ILL), 1'b1);
      wait_done("illegal");
      rd_check("ill_r6_kept", 5'd6, 64'h66);
      rd_check("ill_r1_kept", 5'd1, 64'd5);

      // slt, nor, and, or on r1=2, r2=9
      preload(5'd1, 64'd2); preload(5'd2, 64'd9);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd6, 5'd0, FN_SLT),
            mk("slt_r6", 1'b0, 1'b0, 1'b0, 1'b1, C_SLT), 1'b1);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd7, 5'd0, FN_NOR),
            mk("nor_r7", 1'b0, 1'b0, 1'b1, 1'b1, C_NOR), 1'b1);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd10, 5'd0, FN_AND),
            mk("and_r10", 1'b0, 1'b1, 1'b0, 1'b1, C_AND), 1'b1);
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd11, 5'd0, FN_OR),
            mk("or_r11", 1'b0, 1'b0, 1'b0, 1'b1, C_OR), 1'b1);
      wait_done("logic_ops");
      rd_check("slt_r6_val", 5'd6, 64'd1);
      rd_check("nor_r7_val", 5'd7, 64'hFFFF_FFFF_FFFF_FFF4);
      rd_check("and_r10_val", 5'd10, 64'd0);
      rd_check("or_r11_val", 5'd11, 64'd11);

      // Three back-to-back with instr_valid held high and an r3 dependency
      preload(5'd1, 64'd5); preload(5'd2, 64'd3);
      stream[0] = rinstr(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD);
      stream[1] = rinstr(6'h00, 5'd3, 5'd1, 5'd3, 5'd0, FN_ADD);
      stream[2] = rinstr(6'h00, 5'd3, 5'd2, 5'd9, 5'd0, FN_SUB);
      stream_e[0] = mk("b2b_0", 1'b0, 1'b0, 1'b0, 1'b1, C_ADD);
      stream_e[1] = mk("b2b_1", 1'b0, 1'b0, 1'b0, 1'b1, C_ADD);
      stream_e[2] = mk("b2b_2", 1'b0, 1'b0, 1'b1, 1'b1, C_SUB);
      @(negedge clk);
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.instr = stream[i];
         mon_e = stream_e[i];
         mon_e.acc = cyc;
         exp_q.push_back(mon_e);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.instr = rinstr(6'h00, 5'd1, 5'd1, 5'd13, 5'd0, FN_ADD);
            check($sformatf("b2b_%0d_ready_low_%0d", i, k), {63'd0, bus.instr_ready}, 64'd0);
         end
         if (i == 2) bus.instr_valid = 1'b0;
         @(negedge clk);
         check($sformatf("b2b_%0d_ready_back", i), {63'd0, bus.instr_ready}, 64'd1);
      end
      wait_done("b2b");
      rd_check("b2b_r3", 5'd3, 64'd13);
      rd_check("b2b_r9", 5'd9, 64'd10);
      rd_check("b2b_r13_untouched", 5'd13, 64'd0);

      // Reset asserted while in EXEC: abandon, no done
      issue(rinstr(6'h00, 5'd1, 5'd2, 5'd8, 5'd0, FN_ADD),
            mk("rst_exec", 1'b0, 1'b0, 1'b0, 1'b1, C_ADD), 1'b0);
      @(negedge clk);
      check("exec_ready_low", {63'd0, bus.instr_ready}, 64'd0);
      check("exec_alu_a", bus.alu_a, 64'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_exec_ready", {63'd0, bus.instr_ready}, 64'd1);
      check("rst_exec_alu_a", bus.alu_a, 64'd0);
      check("rst_exec_ctrl", {59'd0, bus.alu_ainv, bus.alu_binv, bus.alu_cin, bus.alu_op}, 64'd0);
      dcount = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.done) dcount++;
         @(negedge clk);
      end
      check("rst_exec_no_done", 64'(dcount), 64'd0);
      rd_check("rst_exec_r8", 5'd8, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
